// File: rtl/stream_fifo_fwft.sv
// Single-clock valid/ready stream FIFO with first-word-fall-through output,
// registered occupancy flags, synchronous flush and an optional drop-on-full mode.
module stream_fifo_fwft #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned LOSSY     = 0
) (
    input  logic                     wclk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_payload,
    input  logic                     flush,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         pop_payload,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);
    localparam logic [15:0]   DROP_MAX = 16'hFFFF;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [LW-1:0]    wr_ptr_q, rd_ptr_q, level_q;
    logic [LW-1:0]    wr_ptr_next, rd_ptr_next, level_next;
    logic             pop_valid_q, push_ready_q;
    logic             almost_full_q, almost_empty_q;
    logic [WIDTH-1:0] pop_payload_q, head_next;
    logic [15:0]      drop_cnt_q, drop_cnt_next;
    logic             wr_en, pop_acc, drop;

    // Next-state: handshakes, pointer/level update and prefetch of the next head word.
    always_comb begin
        wr_en         = 1'b0;
        pop_acc       = 1'b0;
        drop          = 1'b0;
        level_next    = level_q;
        wr_ptr_next   = wr_ptr_q;
        rd_ptr_next   = rd_ptr_q;
        head_next     = pop_payload_q;
        drop_cnt_next = drop_cnt_q;

        if (flush) begin
            level_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            // A full FIFO never accepts, even with a pop in the same cycle.
            wr_en   = push_valid && (level_q != FULL_LVL);
            pop_acc = pop_valid_q && pop_ready;
            drop    = (LOSSY != 0) && push_valid && (level_q == FULL_LVL);

            level_next  = level_q + LW'(wr_en) - LW'(pop_acc);
            wr_ptr_next = wr_ptr_q + LW'(wr_en);
            rd_ptr_next = rd_ptr_q + LW'(pop_acc);

            if (drop && (drop_cnt_q != DROP_MAX)) begin
                drop_cnt_next = drop_cnt_q + 16'd1;
            end

            // Word being written becomes the head when nothing older remains.
            if (level_next != '0) begin
                if (wr_en && (wr_ptr_q == rd_ptr_next)) begin
                    head_next = push_payload;
                end else begin
                    head_next = mem[rd_ptr_next[AW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            pop_valid_q    <= 1'b0;
            push_ready_q   <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            pop_payload_q  <= '0;
            drop_cnt_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_next;
            rd_ptr_q       <= rd_ptr_next;
            level_q        <= level_next;
            pop_valid_q    <= (level_next != '0);
            push_ready_q   <= (LOSSY != 0) || (level_next != FULL_LVL);
            almost_full_q  <= (level_next >= AF_LVL);
            almost_empty_q <= (level_next <= AE_LVL);
            pop_payload_q  <= head_next;
            drop_cnt_q     <= drop_cnt_next;
        end
    end

    // Storage array; holds no reset so it maps onto plain RAM.
    always_ff @(posedge wclk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= push_payload;
        end
    end

    assign push_ready   = push_ready_q;
    assign pop_valid    = pop_valid_q;
    assign pop_payload  = pop_payload_q;
    assign level        = level_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_stream_fifo_fwft.sv
// Bench for stream_fifo_fwft: a backpressure instance (index 0) and a lossy
// instance (index 1) run against a queue-based model of the FIFO rules.
module tb_stream_fifo_fwft;

    localparam int unsigned DEPTH = 16;

    logic        wclk;
    logic        rst_n;
    logic        push_valid   [2];
    logic        push_ready   [2];
    logic [7:0]  push_payload [2];
    logic        flush        [2];
    logic        pop_valid    [2];
    logic        pop_ready    [2];
    logic [7:0]  pop_payload  [2];
    logic [4:0]  level        [2];
    logic        almost_full  [2];
    logic        almost_empty [2];
    logic [15:0] drop_cnt     [2];

    logic [7:0]  mq0[$];
    logic [7:0]  mq1[$];
    logic [15:0] mdrop [2];
    int          n_checks;
    int          n_fail;
    bit          chk_en;

    stream_fifo_fwft #(
        .WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .LOSSY(0)
    ) u_dut_bp (
        .wclk(wclk), .rst_n(rst_n),
        .push_valid(push_valid[0]), .push_ready(push_ready[0]), .push_payload(push_payload[0]),
        .flush(flush[0]),
        .pop_valid(pop_valid[0]), .pop_ready(pop_ready[0]), .pop_payload(pop_payload[0]),
        .level(level[0]), .almost_full(almost_full[0]), .almost_empty(almost_empty[0]),
        .drop_cnt(drop_cnt[0])
    );

    stream_fifo_fwft #(
        .WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .LOSSY(1)
    ) u_dut_lossy (
        .wclk(wclk), .rst_n(rst_n),
        .push_valid(push_valid[1]), .push_ready(push_ready[1]), .push_payload(push_payload[1]),
        .flush(flush[1]),
        .pop_valid(pop_valid[1]), .pop_ready(pop_ready[1]), .pop_payload(pop_payload[1]),
        .level(level[1]), .almost_full(almost_full[1]), .almost_empty(almost_empty[1]),
        .drop_cnt(drop_cnt[1])
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string nm(input int k, input string what);
        return $sformatf("%s %s", (k == 0) ? "bp" : "lossy", what);
    endfunction

    task automatic drive(input int k, input logic pv, input logic pr, input logic fl, input logic [7:0] d);
        push_valid[k]   = pv;
        pop_ready[k]    = pr;
        flush[k]        = fl;
        push_payload[k] = d;
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Behavioural rule for one clock edge: flush wins, a full FIFO refuses the
    // push (counted as a drop in lossy mode), the head leaves on pop.
    task automatic model_step(input int k);
        logic [7:0] q[$];
        bit         full;
        if (k == 0) q = mq0; else q = mq1;
        if (flush[k]) begin
            q.delete();
        end else begin
            full = (q.size() == DEPTH);
            if (pop_ready[k] && q.size() != 0) q.delete(0);
            if (push_valid[k] && !full) q.push_back(push_payload[k]);
            else if (push_valid[k] && full && k == 1 && mdrop[k] != 16'hFFFF) mdrop[k]++;
        end
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic check_outputs(input int k);
        int         n;
        logic [7:0] head;
        if (k == 0) begin
            n = mq0.size();
            head = (n != 0) ? mq0[0] : 8'h00;
        end else begin
            n = mq1.size();
            head = (n != 0) ? mq1[0] : 8'h00;
        end
        check(nm(k, "level"), 32'(level[k]), 32'(n));
        check(nm(k, "pop_valid"), 32'(pop_valid[k]), 32'(n != 0));
        check(nm(k, "push_ready"), 32'(push_ready[k]), 32'((k == 1) || (n != DEPTH)));
        check(nm(k, "almost_full"), 32'(almost_full[k]), 32'(n >= 14));
        check(nm(k, "almost_empty"), 32'(almost_empty[k]), 32'(n <= 2));
        check(nm(k, "drop_cnt"), 32'(drop_cnt[k]), 32'(mdrop[k]));
        if (n != 0) check(nm(k, "pop_payload"), 32'(pop_payload[k]), 32'(head));
    endtask

    task automatic check_reset(input int k);
        check(nm(k, "rst level"), 32'(level[k]), 32'd0);
        check(nm(k, "rst pop_valid"), 32'(pop_valid[k]), 32'd0);
        check(nm(k, "rst pop_payload"), 32'(pop_payload[k]), 32'd0);
        check(nm(k, "rst almost_full"), 32'(almost_full[k]), 32'd0);
        check(nm(k, "rst almost_empty"), 32'(almost_empty[k]), 32'd1);
        check(nm(k, "rst drop_cnt"), 32'(drop_cnt[k]), 32'd0);
        check(nm(k, "rst push_ready"), 32'(push_ready[k]), 32'd1);
    endtask

    task automatic cycle();
        @(posedge wclk);
        model_step(0);
        model_step(1);
        #1;
        if (chk_en) begin
            check_outputs(0);
            check_outputs(1);
        end
    endtask

    task automatic fill(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            drive(k, 1'b1, 1'b0, 1'b0, 8'($urandom));
            cycle();
        end
        drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            drive(k, 1'b0, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b1;
        mdrop[0] = '0;
        mdrop[1] = '0;
        rst_n    = 1'b0;
        idle();

        #12;
        check_reset(0);
        check_reset(1);
        @(negedge wclk);
        rst_n = 1'b1;
        cycle();

        // Fill 0x00..0x0F with the consumer stalled, then one refused push.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 1'b0, 1'b0, 8'(i));
            cycle();
        end
        check("fill level", 32'(level[0]), 32'd16);
        check("fill push_ready", 32'(push_ready[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'hEE);
        cycle();
        for (int i = 0; i < 16; i++) begin
            check("drain order", 32'(pop_payload[0]), 32'(i));
            drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        check("drain almost_empty", 32'(almost_empty[0]), 32'd1);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

        // First-word fall-through and hold under stall.
        drive(0, 1'b1, 1'b0, 1'b0, 8'hA5);
        cycle();
        check("fwft pop_valid", 32'(pop_valid[0]), 32'd1);
        check("fwft payload", 32'(pop_payload[0]), 32'hA5);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("fwft hold", 32'(pop_payload[0]), 32'hA5);
        end
        drain(0, 1);

        // Streaming at constant occupancy.
        fill(0, 5);
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 8'($urandom));
            cycle();
        end
        check("stream level", 32'(level[0]), 32'd5);
        drain(0, 5);

        // Flush with both handshakes active, then a fresh first word.
        fill(0, 9);
        drive(0, 1'b1, 1'b1, 1'b1, 8'h77);
        cycle();
        check("flush level", 32'(level[0]), 32'd0);
        check("flush pop_valid", 32'(pop_valid[0]), 32'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h3C);
        cycle();
        check("post-flush head", 32'(pop_payload[0]), 32'h3C);
        drain(0, 1);

        // Lossy: three pushes at full, the last one alongside a pop.
        fill(1, 16);
        drive(1, 1'b1, 1'b0, 1'b0, 8'hD1);
        cycle();
        drive(1, 1'b1, 1'b0, 1'b0, 8'hD2);
        cycle();
        drive(1, 1'b1, 1'b1, 1'b0, 8'hD3);
        cycle();
        check("lossy drops", 32'(drop_cnt[1]), 32'd3);
        check("lossy level", 32'(level[1]), 32'd15);
        drain(1, 15);

        // Random traffic on both instances, producer-heavy then consumer-heavy.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                drive(k, (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                      (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 31) == 0, 8'($urandom));
            end
            cycle();
        end
        idle();
        cycle();

        // Asynchronous reset between edges with data in flight.
        drive(0, 1'b0, 1'b0, 1'b1, 8'h00);
        cycle();
        fill(0, 7);
        check("pre-reset level", 32'(level[0]), 32'd7);
        #3;
        rst_n = 1'b0;
        #1;
        mq0.delete();
        mq1.delete();
        mdrop[0] = '0;
        mdrop[1] = '0;
        check_reset(0);
        check_reset(1);
        idle();
        @(negedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h11);
        cycle();
        check("post-reset head", 32'(pop_payload[0]), 32'h11);
        drain(0, 1);

        // Long drop run to reach the counter ceiling.
        fill(1, 16);
        chk_en = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 65540; i++) cycle();
        chk_en = 1'b1;
        cycle();
        check("drop saturate", 32'(drop_cnt[1]), 32'hFFFF);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h5B);
        cycle();
        check("drop hold", 32'(drop_cnt[1]), 32'hFFFF);
        drain(1, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo_fwft.md
Name: stream_fifo_fwft

Overview:
Parametrised single-clock stream FIFO, the successor to the basic stream FIFO. It uses valid/ready on both sides and presents data first-word-fall-through (FWFT). New features: registered almost-full/almost-empty flags, exact occupancy, synchronous flush, and a selectable lossy mode that drops on full and counts the drops. It sits between stream producers and consumers in the crossbar datapath, for rate decoupling and credit estimation.

Parameters:
WIDTH, 8, payload width in bits (>=1)
DEPTH, 16, total capacity in entries, including the output stage; power of 2, >=4
AF_THRESH, 14, almost_full asserted when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH (0..DEPTH-1)
LOSSY, 0, 0 = backpressure mode; 1 = drop-new-on-full mode

Ports:
wclk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
push_valid  in  1  producer data valid
push_ready  out  1  FIFO can accept
push_payload  in  WIDTH  producer data
flush  in  1  synchronous clear, highest priority
pop_valid  out  1  head entry valid
pop_ready  in  1  consumer accepts head
pop_payload  out  WIDTH  head entry data
level  out  $clog2(DEPTH)+1  entries stored, 0..DEPTH
almost_full  out  1  level >= AF_THRESH (registered)
almost_empty  out  1  level <= AE_THRESH (registered)
drop_cnt  out  16  pushes discarded on full (LOSSY=1 only), saturating

Behaviour:
- Reset (async assert, sync-release safe):
  - level=0, pop_valid=0, pop_payload=0, almost_full=0, almost_empty=1, drop_cnt=0.
  - push_ready=1 (both modes).
- Push handshake: accepted when push_valid && push_ready at a rising edge.
- Pop handshake: accepted when pop_valid && pop_ready at a rising edge.
- push_ready:
  - LOSSY=0: push_ready = (level != DEPTH). Derived from registered state only; no combinational path from pop_ready.
  - LOSSY=1: push_ready = 1 always. A push while level==DEPTH is discarded and drop_cnt increments, saturating at 16'hFFFF. A pop in the same cycle does not rescue the push.
- pop_valid = (level != 0), registered.
- FWFT latency: a push accepted into an empty FIFO at edge N gives pop_valid=1 with that payload after edge N; it is consumable at edge N+1.
- pop_payload holds stable while pop_valid && !pop_ready. After an accepted pop, the next entry (if any) appears in the following cycle, with no bubble.
- Simultaneous push+pop at 0 < level < DEPTH: level unchanged, order preserved.
- Simultaneous push+pop at level==0: only the push takes effect.
- Ordering is strict FIFO. Pointers are $clog2(DEPTH)+1 bits with wrap bit; wrap-around is transparent.
- level update: level_next = level + push_acc - pop_acc. Registered; reflects the edge just taken. Never exceeds DEPTH, never underflows.
- almost_full and almost_empty are computed from level_next and registered, so they are cycle-aligned with level.
- Flush: when flush=1 at an edge, pointers, level and pop_valid are cleared (level=0, pop_valid=0, almost_empty=1, almost_full=0) after that edge.
  - A push or pop handshake in the flush cycle is discarded and not counted as a drop.
  - drop_cnt is not cleared by flush.
  - pop_payload value is don't-care while pop_valid=0.
- Storage: RAM array plus output register, total capacity exactly DEPTH.
- Reset mid-operation: all state is cleared immediately; contents are lost; behaviour after release is identical to power-up.

Test Plan:
- Fill/drain, LOSSY=0, DEPTH=16: push 0x00..0x0F back-to-back with pop_ready=0 -> push_ready falls after the 16th accept, level=16, almost_full=1 from level 14. Then pop_ready=1 -> 0x00..0x0F out in order, one per cycle, with no bubbles; level=0 and almost_empty=1 at the end.
- FWFT latency: empty FIFO, push 0xA5 at edge N -> pop_valid=1 and pop_payload=0xA5 after edge N. With pop_ready held 0 for 5 cycles, the payload stays 0xA5.
- Streaming: level=5, continuous push+pop for 100 cycles with random data -> level stays 5, output sequence equals input sequence delayed by 5 entries.
- Flush: level=9 with push_valid=1 and pop_ready=1 in the flush cycle -> level=0, pop_valid=0 next cycle. The following push 0x3C is the first word popped.
- Lossy mode, LOSSY=1: fill to 16, then push 3 more words (one coinciding with a pop) -> drop_cnt=3, level=15 after the pop, the dropped words never appear. Preload drop_cnt near saturation via a long drop run -> holds at 0xFFFF.
- Reset mid-operation: at level=7, assert rst_n=0 asynchronously, between edges -> outputs at reset values immediately. After release, push 0x11 -> first pop returns 0x11.
